// File: rtl/ups_pkg.sv
// Shared types and constants for the UPS DAC serial path.
// Holds the SPI transmitter state encoding and frame width.
package ups_pkg;

  typedef enum logic [2:0] {
    SPI_IDLE,
    SPI_SETUP,
    SPI_SHIFT,
    SPI_HOLD,
    SPI_GAP
  } spi_state_t;

  localparam int DAC_FRAME_BITS = 24;

endpackage

// File: rtl/ups_tick_gen.sv
// Reloadable down-counter: one-cycle tick every load_i cycles.
// Ports: clk_i, rst_i, start_i (reload now), load_i (period), tick_o.
module ups_tick_gen #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] load_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // The tick marks the last cycle of an interval, so the
  // counter holds load-1 in the first cycle after a start.
  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (start_i || cnt_q == '0) begin
      cnt_d = load_i - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/ups_dac_spi.sv
// 24-bit SPI frame transmitter for one UPS DAC channel.
// Ports: clk, rst, dac/dac_dv in; dac_sclk/cs_n/mosi, busy, done, overrun_cnt out.
module ups_dac_spi
  import ups_pkg::*;
#(
  parameter int          CLK_DIV   = 2,
  parameter int          CS_SETUP  = 2,
  parameter int          CS_HOLD   = 2,
  parameter int          GAP       = 4,
  parameter logic [7:0]  CTRL_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dac,
  input  logic        dac_dv,
  output logic        dac_sclk,
  output logic        dac_cs_n,
  output logic        dac_mosi,
  output logic        busy,
  output logic        done,
  output logic [15:0] overrun_cnt
);

  localparam logic [4:0] LAST_BIT = 5'(DAC_FRAME_BITS - 1);

  spi_state_t state_q, state_d;
  logic [DAC_FRAME_BITS-1:0] sr_q, sr_d;
  logic [4:0]  bit_q, bit_d;
  logic        half_q, half_d;
  logic        pend_q, pend_d;
  logic [15:0] pword_q, pword_d;
  logic [15:0] ovr_q, ovr_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        cs_n_q, cs_n_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic        tick;
  logic        start;
  logic [7:0]  load;

  ups_tick_gen #(.W(8)) u_tick (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start),
    .load_i (load),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    half_d  = half_q;
    pend_d  = pend_q;
    pword_d = pword_q;
    ovr_d   = ovr_q;
    start   = 1'b0;
    load    = 8'(CLK_DIV);

    unique case (state_q)
      SPI_IDLE: begin
        if (dac_dv || pend_q) begin
          state_d = SPI_SETUP;
          sr_d    = {CTRL_BYTE, dac_dv ? dac : pword_q};
          pend_d  = 1'b0;
          start   = 1'b1;
          load    = 8'(CS_SETUP);
        end
      end
      SPI_SETUP: begin
        if (tick) begin
          state_d = SPI_SHIFT;
          bit_d   = '0;
          half_d  = 1'b0;
          start   = 1'b1;
        end
      end
      SPI_SHIFT: begin
        if (tick) begin
          start = 1'b1;
          if (!half_q) begin
            half_d = 1'b1;
          end else if (bit_q == LAST_BIT) begin
            state_d = SPI_HOLD;
            load    = 8'(CS_HOLD);
          end else begin
            // next bit appears with the SCLK rise
            bit_d  = bit_q + 1'b1;
            half_d = 1'b0;
            sr_d   = {sr_q[DAC_FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      SPI_HOLD: begin
        if (tick) begin
          state_d = SPI_GAP;
          start   = 1'b1;
          load    = 8'(GAP);
        end
      end
      SPI_GAP: begin
        if (tick) begin
          state_d = SPI_IDLE;
        end
      end
      default: state_d = SPI_IDLE;
    endcase

    // one-deep, latest-wins holding slot
    if (dac_dv && state_q != SPI_IDLE) begin
      pend_d  = 1'b1;
      pword_d = dac;
      if (pend_q && ovr_q != 16'hFFFF) begin
        ovr_d = ovr_q + 16'd1;
      end
    end
  end

  // outputs are registered from next-state values
  always_comb begin
    sclk_d = (state_d == SPI_SHIFT) && !half_d;
    mosi_d = (state_d == SPI_SHIFT) && sr_d[DAC_FRAME_BITS-1];
    cs_n_d = (state_d == SPI_IDLE) || (state_d == SPI_GAP);
    done_d = (state_q == SPI_HOLD) && (state_d == SPI_GAP);
    busy_d = (state_d != SPI_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SPI_IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      half_q  <= 1'b0;
      pend_q  <= 1'b0;
      pword_q <= '0;
      ovr_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      pend_q  <= pend_d;
      pword_q <= pword_d;
      ovr_q   <= ovr_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign dac_sclk    = sclk_q;
  assign dac_mosi    = mosi_q;
  assign dac_cs_n    = cs_n_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign overrun_cnt = ovr_q;

endmodule
